// File: rtl/accum64_ctrl_pkg.sv
// accum64_ctrl_pkg: shared types and constants for the 64-bit accumulator controller.
// Contents: controller state enum, datapath width, default operand-count width and the
// block split used by the carry-select adder.
package accum64_ctrl_pkg;

  localparam int unsigned WIDTH       = 64;
  localparam int unsigned COUNT_W_DEF = 8;

  // Carry-select adder split: four 16-bit blocks, each pre-computing both carry-in cases.
  localparam int unsigned BLK_W   = 16;
  localparam int unsigned NUM_BLK = WIDTH / BLK_W;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

endpackage

// File: rtl/accum64_ctrl_if.sv
// accum64_ctrl_if: run-control, operand stream and result stream of the accumulator.
// Signals:
//   start/count                         run request and operand count (master -> slave)
//   in_valid/in_ready/in_data/in_sub    operand stream (master -> slave, ready back)
//   out_valid/out_ready/out_sum/
//   out_carry/out_ovf                   result stream (slave -> master, ready back)
//   busy                                run in progress (slave -> master)
interface accum64_ctrl_if
  import accum64_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
);

  logic               start;
  logic [COUNT_W-1:0] count;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_sub;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic               out_carry;
  logic               out_ovf;
  logic               busy;

  modport master (
    output start, count, in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

endinterface

// File: rtl/accum64_ctrl_acc_datapath.sv
// accum64_ctrl_acc_datapath: carry-select adder, operand invert mux, overflow detect and the
// accumulator / sticky-flag registers.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        zero the accumulator and flags (start of a run)
//   i_load         capture adder sum and update flags (operand handshake)
//   i_data, i_sub  operand and add/subtract select
//   o_acc          accumulator value
//   o_carry        sticky OR of adder carry-out
//   o_ovf          sticky two's-complement overflow
module accum64_ctrl_acc_datapath
  import accum64_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam logic [BLK_W:0] BlkOne = (BLK_W + 1)'(1);

  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [NUM_BLK:0] w_c;
  logic             w_ovf;

  // Subtraction as acc + ~data + 1; carry-out of 1 then means "no borrow".
  assign w_b    = i_sub ? ~i_data : i_data;
  assign w_c[0] = i_sub;

  // Each block computes both carry-in outcomes in parallel; the incoming carry only selects.
  for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
    logic [BLK_W:0] w_s0;
    logic [BLK_W:0] w_s1;
    assign w_s0 = {1'b0, r_acc[g*BLK_W +: BLK_W]} + {1'b0, w_b[g*BLK_W +: BLK_W]};
    assign w_s1 = w_s0 + BlkOne;
    assign w_sum[g*BLK_W +: BLK_W] = w_c[g] ? w_s1[BLK_W-1:0] : w_s0[BLK_W-1:0];
    assign w_c[g+1]                = w_c[g] ? w_s1[BLK_W]     : w_s0[BLK_W];
  end

  // Same-sign inputs producing a sum of the other sign.
  assign w_ovf = (r_acc[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_acc   <= w_sum;
      r_carry <= r_carry | w_c[NUM_BLK];
      r_ovf   <= r_ovf | w_ovf;
    end
  end

  assign o_acc   = r_acc;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/accum64_ctrl.sv
// accum64_ctrl: sequential front/back end for the 64-bit carry-select adder. Accepts a
// programmed number of operands, accumulates them, and presents the total with sticky
// carry/overflow flags on a valid/ready result port.
// Ports:
//   i_clk   clock, all state updates on rising edge
//   i_rst   synchronous active-high reset; aborts any run in progress
//   bus     accum64_ctrl_if slave: start/count, operand stream, result stream, busy
module accum64_ctrl
  import accum64_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  accum64_ctrl_if.slave bus
);

  state_e             r_state;
  state_e             w_state_next;
  logic [COUNT_W-1:0] r_remaining;
  logic [COUNT_W-1:0] w_remaining_next;
  logic               w_clear;
  logic               w_load;
  logic               w_in_ready;

  logic [WIDTH-1:0]   w_acc;
  logic               w_carry;
  logic               w_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
    end
  end

  // Handshake qualifier is decoded from state only, so no in_valid -> in_ready path.
  assign w_in_ready = (r_state == StAccum);

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_clear          = 1'b0;
    w_load           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_clear          = 1'b1;
          w_remaining_next = bus.count;
          w_state_next     = (bus.count == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          w_load           = 1'b1;
          w_remaining_next = r_remaining - COUNT_W'(1);
          if (r_remaining == COUNT_W'(1)) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        // start is ignored here, even on the exit cycle.
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  accum64_ctrl_acc_datapath u_datapath (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_data  (bus.in_data),
    .i_sub   (bus.in_sub),
    .o_acc   (w_acc),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state == StAccum) || (r_state == StDone);
  // Registers only change on load/clear, neither of which can occur in DONE.
  assign bus.out_sum   = w_acc;
  assign bus.out_carry = w_carry;
  assign bus.out_ovf   = w_ovf;

endmodule

// File: doc/accum64_ctrl.md
Name: accum64_ctrl

Overview:
- Sequential front/back end for the team's 64-bit carry-select adder.
- Accepts a programmed number of 64-bit operands over a valid/ready stream and drives each one, with the running total, into the adder.
- Captures each sum into an accumulator register, keeps sticky carry and signed-overflow flags, and presents the final total on a valid/ready result port.
- Sits between the operand source (register file or test driver) and the result consumer.

Parameters:
- WIDTH, 64, datapath width; fixed to match the 64-bit adder; other values unsupported.
- COUNT_W, 8, width of operand-count field; max 2^COUNT_W-1 operands per run.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- count  input  COUNT_W  number of operands in the run; sampled with start
- in_valid  input  1  operand valid
- in_ready  output  1  block will accept operand this cycle
- in_data  input  WIDTH  operand
- in_sub  input  1  1 = subtract in_data from total, 0 = add
- out_valid  output  1  final result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  accumulated total, modulo 2^64
- out_carry  output  1  sticky OR of adder c_out over the run
- out_ovf  output  1  sticky two's-complement overflow over the run
- busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset: one clock, synchronous, active-high. On reset: state=IDLE, acc=0, remaining=0, out_carry=0, out_ovf=0, out_valid=0, in_ready=0, busy=0. Reset mid-run aborts it; IDLE on the next edge, partial total discarded.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with count!=0: acc<=0, flags<=0, remaining<=count, go to ACCUM.
  - start=1 with count==0: acc<=0, flags<=0, go directly to DONE.
- ACCUM:
  - in_ready=1.
  - Handshake (in_valid & in_ready) accepts one operand per cycle. Gaps in in_valid are allowed.
  - Adder inputs: a=acc, b=in_sub ? ~in_data : in_data, c_in=in_sub.
  - On handshake: acc<=sum; out_carry<=out_carry|c_out; out_ovf<=out_ovf|((a[63]==b[63]) & (sum[63]!=a[63])); remaining<=remaining-1.
  - On the handshake with remaining==1: go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum=acc; out_sum, out_carry and out_ovf are held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE.
  - start is ignored in ACCUM and DONE, including the cycle in which DONE exits. A new run needs one IDLE cycle.
- Latency:
  - out_valid rises on the edge after the last operand handshake.
  - Minimum run time is count+1 cycles from start to out_valid.
- Arithmetic:
  - Wrap modulo 2^64, no saturation.
  - For subtraction, c_out=1 means no borrow.
- Outputs are registered or decoded from state only. No combinational path from in_valid to in_ready or from out_ready to out_valid.

Decomposition:
- Shared package holds: the state enum (IDLE/ACCUM/DONE), WIDTH=64, and the default COUNT_W.
- One natural sub-module: acc_datapath. It contains the adder instance, the operand invert mux, the overflow detect, and the acc/flag registers.
- The top level keeps the FSM and the remaining counter.

Test Plan:
1. start, count=3, add 5, 7, 9 back-to-back -> out_sum=21, out_carry=0, out_ovf=0, out_valid one cycle after the 3rd handshake.
2. count=2, add 0xFFFF_FFFF_FFFF_FFFF then 2 -> out_sum=1, out_carry=1, out_ovf=0.
3. count=2, add 0x7FFF_FFFF_FFFF_FFFF then 1 -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_carry=0.
4. count=2, add 10 then sub 3 -> out_sum=7, out_carry=1 (no borrow from the subtract).
5. count=4 with in_valid toggling every other cycle, and out_ready held low 5 cycles in DONE -> out_sum=sum of all operands, held stable, in_ready=0 during DONE, start pulses in DONE ignored.
6. count=0 -> out_valid next cycle with out_sum=0. Separately, rst asserted after 2 of 4 operands -> IDLE next edge, out_valid=0, busy=0; the following run starts from acc=0.
